// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scan controller.
// Imported by scan_tick_gen and keypad_scan_ctrl.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'hF;

  function automatic logic [3:0] key_code_f(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Lowest-numbered row pulled low; the caller guarantees at least one is low.
  function automatic logic [1:0] low_row_f(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive_f(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-clk scan-tick enable every CLK_DIV clocks,
// keeping the keypad logic on the single system clock.
module scan_tick_gen
  import keypad_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int TICK_W  = 32
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] CNT_ONE  = TICK_W'(1);

  logic [TICK_W-1:0] cnt_r;

  assign tick = (cnt_r == CNT_LAST);

  // Tick counter, wrapping to zero on the tick cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-hot column drive, synchronized row sampling,
// press/release debounce and a valid/ack key handoff with overrun reporting.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int TICK_W   = 32,
  parameter int DB_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_lost
);

  localparam int CNT_W = $clog2(DB_TICKS + 1) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                tick;
  logic [NUM_ROWS-1:0] sync1_r;
  logic [NUM_ROWS-1:0] rs_r;
  kp_state_t           state_r;
  logic [1:0]          col_idx_r;
  logic [1:0]          row_idx_r;
  logic [CNT_W-1:0]    cnt_r;

  logic       pressed_s;
  logic       row_low_s;
  logic       accept_s;
  logic [1:0] low_row_s;
  logic [1:0] acc_row_s;
  logic [1:0] col_next_s;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .TICK_W  (TICK_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= ROWS_IDLE;
      rs_r    <= ROWS_IDLE;
    end else begin
      sync1_r <= row_in;
      rs_r    <= sync1_r;
    end
  end

  // Accept decision: with DB_TICKS==1 a key is accepted on the tick it is found.
  always_comb begin
    pressed_s  = (rs_r != ROWS_IDLE);
    low_row_s  = low_row_f(rs_r);
    row_low_s  = ~rs_r[row_idx_r];
    col_next_s = col_idx_r + 2'd1;
    acc_row_s  = row_idx_r;
    accept_s   = 1'b0;
    case (state_r)
      SCAN: begin
        accept_s  = tick && pressed_s && (DB_LAST == '0);
        acc_row_s = low_row_s;
      end
      DEBOUNCE: accept_s = tick && row_low_s && (cnt_r == DB_LAST);
      default:  accept_s = 1'b0;
    endcase
  end

  // Scan/debounce FSM; the column stays frozen while a key is being tracked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= SCAN;
      col_idx_r <= 2'd0;
      row_idx_r <= 2'd0;
      cnt_r     <= '0;
      col_out   <= 4'b1110;
    end else if (tick) begin
      case (state_r)
        SCAN: begin
          if (pressed_s) begin
            row_idx_r <= low_row_s;
            cnt_r     <= CNT_ONE;
            if (DB_LAST == '0) begin
              state_r <= HELD;
            end else begin
              state_r <= DEBOUNCE;
            end
          end else begin
            col_idx_r <= col_next_s;
            col_out   <= col_drive_f(col_next_s);
          end
        end
        DEBOUNCE: begin
          if (row_low_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == DB_LAST) begin
              state_r <= HELD;
            end else begin
              state_r <= DEBOUNCE;
            end
          end else begin
            state_r   <= SCAN;
            col_idx_r <= col_next_s;
            col_out   <= col_drive_f(col_next_s);
          end
        end
        HELD: begin
          if (!row_low_s) begin
            cnt_r <= CNT_ONE;
            if (DB_LAST == '0) begin
              state_r   <= SCAN;
              col_idx_r <= col_next_s;
              col_out   <= col_drive_f(col_next_s);
            end else begin
              state_r <= RELEASE;
            end
          end else begin
            state_r <= HELD;
          end
        end
        RELEASE: begin
          if (!row_low_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == DB_LAST) begin
              state_r   <= SCAN;
              col_idx_r <= col_next_s;
              col_out   <= col_drive_f(col_next_s);
            end else begin
              state_r <= RELEASE;
            end
          end else begin
            state_r <= HELD;
          end
        end
        default: state_r <= SCAN;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Key handoff: an ack in the accept cycle frees the slot for the new code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_lost  <= 1'b0;
    end else begin
      key_lost <= 1'b0;
      if (accept_s) begin
        if (!key_valid || key_ack) begin
          key_code  <= key_code_f(acc_row_s, col_idx_r);
          key_valid <= 1'b1;
        end else begin
          key_lost <= 1'b1;
        end
      end else if (key_ack) begin
        key_valid <= 1'b0;
      end else begin
        key_valid <= key_valid;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a simulated key matrix drives the rows from the
// bench's own column prediction and a tick-level behavioural model predicts outputs.
module tb_keypad_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DB      = 3;

  logic       clk;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_lost;

  int total;
  int bad;

  logic [15:0] pressed;

  int         m_cnt, m_col, m_lock, m_run, m_up;
  bit         m_down;
  logic [3:0] m_q[$];
  logic [3:0] m_code;
  bit         m_valid, m_lost;

  keypad_scan_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .TICK_W   (32),
    .DB_TICKS (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_lost  (key_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] colpat(int c);
    logic [3:0] p;
    p = 4'hF;
    p[c] = 1'b0;
    return p;
  endfunction

  function automatic logic [3:0] rows_for(int col);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++) if (pressed[i*4+col]) r[i] = 1'b0;
    return r;
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_col = 0; m_lock = -1; m_run = 0; m_up = 0; m_down = 0;
    m_q.delete();
    m_q.push_back(4'hF);
    m_q.push_back(4'hF);
    m_code = 4'h0; m_valid = 0; m_lost = 0;
  endfunction

  function automatic bit model_will_accept();
    logic [3:0] rs;
    rs = m_q[0];
    if (m_cnt != CLK_DIV - 1) return 0;
    if (m_lock < 0) return (rs != 4'hF) && (DB == 1);
    return !m_down && !rs[m_lock] && (m_run + 1 == DB);
  endfunction

  // Advance the model by one clock using pre-edge inputs, then clock the DUT.
  task automatic step();
    logic [3:0] rs;
    bit tk, acc;
    int lr;
    rs = m_q[0];
    tk = (m_cnt == CLK_DIV - 1);
    acc = 0;
    if (tk) begin
      if (m_lock < 0) begin
        if (rs == 4'hF) m_col = (m_col + 1) % 4;
        else begin
          lr = 0;
          while (lr < 3 && rs[lr]) lr++;
          m_lock = lr; m_run = 1; m_down = 0; m_up = 0;
          if (m_run == DB) begin acc = 1; m_down = 1; end
        end
      end else if (!m_down) begin
        if (!rs[m_lock]) begin
          m_run++;
          if (m_run == DB) begin acc = 1; m_down = 1; end
        end else begin
          m_lock = -1; m_col = (m_col + 1) % 4;
        end
      end else begin
        if (rs[m_lock]) begin
          m_up++;
          if (m_up == DB) begin m_lock = -1; m_col = (m_col + 1) % 4; end
        end else m_up = 0;
      end
    end
    m_lost = 0;
    if (acc) begin
      if (!m_valid || key_ack) begin m_code = 4'(m_lock * 4 + m_col); m_valid = 1; end
      else m_lost = 1;
    end else if (key_ack) m_valid = 0;
    m_cnt = (m_cnt + 1) % CLK_DIV;
    void'(m_q.pop_front());
    m_q.push_back(row_in);
    @(posedge clk);
    #1;
    row_in = rows_for(m_col);
  endtask

  task automatic set_keys(logic [15:0] k);
    pressed = k;
    row_in = rows_for(m_col);
  endtask

  task automatic wait_col_start(int c);
    bit found;
    found = 0;
    for (int i = 0; i < 80; i++) begin
      if (m_col == c && m_cnt == 0 && m_lock < 0) begin found = 1; break; end
      step();
    end
    total++;
    if (!found) begin bad++; $display("FAIL wait_col_start got=timeout want=col%0d", c); end
  endtask

  task automatic test_reset();
    reset = 1'b0; key_ack = 1'b0; pressed = '0; row_in = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL rst_col got=%b want=1110", col_out); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", key_valid); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL rst_code got=%h want=0", key_code); end
    total++; if (key_lost !== 1'b0) begin bad++; $display("FAIL rst_lost got=%b want=0", key_lost); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_idle_scan();
    for (int k = 1; k <= 20; k++) begin
      step();
      total++;
      if (col_out !== colpat((k / CLK_DIV) % 4) || key_valid !== 1'b0 || key_lost !== 1'b0) begin
        bad++;
        $display("FAIL idle_scan k=%0d got col=%b v=%b l=%b want col=%b v=0 l=0",
                 k, col_out, key_valid, key_lost, colpat((k / CLK_DIV) % 4));
      end
    end
  endtask

  task automatic test_press_hold();
    int rises;
    logic prev;
    bit found;
    wait_col_start(1);
    set_keys(16'h0001 << (2 * 4 + 1));
    rises = 0;
    prev = key_valid;
    for (int i = 0; i < 12 * CLK_DIV; i++) begin
      step();
      if (key_valid && !prev) rises++;
      prev = key_valid;
      total++;
      if (key_valid !== m_valid || key_code !== m_code || col_out !== colpat(m_col)) begin
        bad++;
        $display("FAIL hold_cycle got v=%b c=%h col=%b want v=%b c=%h col=%b",
                 key_valid, key_code, col_out, m_valid, m_code, colpat(m_col));
      end
    end
    total++; if (rises !== 1) begin bad++; $display("FAIL hold_rises got=%0d want=1", rises); end
    total++; if (key_code !== 4'h9) begin bad++; $display("FAIL hold_code got=%h want=9", key_code); end
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ack_clear got=%b want=0", key_valid); end
    set_keys('0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (col_out === 4'b1011) begin found = 1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL release_resume got=%b want=1011", col_out); end
  endtask

  task automatic test_bounce();
    wait_col_start(1);
    set_keys(16'h0001 << (2 * 4 + 1));
    for (int i = 0; i < 2 * CLK_DIV; i++) step();
    set_keys('0);
    for (int i = 0; i < CLK_DIV; i++) begin
      step();
      total++;
      if (key_valid !== 1'b0) begin bad++; $display("FAIL bounce_valid got=%b want=0", key_valid); end
    end
    total++; if (col_out !== 4'b1011) begin bad++; $display("FAIL bounce_col got=%b want=1011", col_out); end
  endtask

  task automatic test_lost();
    int pulses;
    if (m_valid) begin key_ack = 1'b1; step(); key_ack = 1'b0; end
    wait_col_start(1);
    set_keys(16'h0001 << (2 * 4 + 1));
    for (int i = 0; i < 5 * CLK_DIV; i++) step();
    total++; if (key_valid !== 1'b1 || key_code !== 4'h9) begin
      bad++; $display("FAIL lost_first got v=%b c=%h want v=1 c=9", key_valid, key_code);
    end
    set_keys('0);
    for (int i = 0; i < 5 * CLK_DIV; i++) step();
    set_keys(16'h0001 << (0 * 4 + 3));
    pulses = 0;
    for (int i = 0; i < 15 * CLK_DIV; i++) begin
      step();
      if (key_lost === 1'b1) pulses++;
      total++;
      if (key_lost !== m_lost || key_code !== 4'h9 || key_valid !== 1'b1) begin
        bad++;
        $display("FAIL lost_cycle got l=%b c=%h v=%b want l=%b c=9 v=1", key_lost, key_code, key_valid, m_lost);
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL lost_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_back_to_back();
    bit hit;
    set_keys('0);
    for (int i = 0; i < 5 * CLK_DIV; i++) step();
    set_keys(16'h0001 << (0 * 4 + 3));
    hit = 0;
    for (int i = 0; i < 20 * CLK_DIV; i++) begin
      if (model_will_accept()) begin
        key_ack = 1'b1;
        hit = 1;
      end
      step();
      key_ack = 1'b0;
      if (hit) break;
    end
    total++; if (!hit) begin bad++; $display("FAIL b2b_accept got=timeout want=accept"); end
    total++; if (key_code !== 4'h3) begin bad++; $display("FAIL b2b_code got=%h want=3", key_code); end
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", key_valid); end
    total++; if (key_lost !== 1'b0) begin bad++; $display("FAIL b2b_lost got=%b want=0", key_lost); end
  endtask

  task automatic test_reset_mid();
    bit found;
    set_keys('0);
    for (int i = 0; i < 5 * CLK_DIV; i++) step();
    set_keys(16'h0001 << (1 * 4 + 2));
    found = 0;
    for (int i = 0; i < 30 * CLK_DIV; i++) begin
      step();
      if (m_lock >= 0 && !m_down) begin found = 1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_debounce got=timeout want=debounce"); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL mid_rst_col got=%b want=1110", col_out); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", key_valid); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL mid_rst_code got=%h want=0", key_code); end
    pressed = '0;
    row_in = 4'hF;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= CLK_DIV; k++) begin
      step();
      total++;
      if (col_out !== ((k == CLK_DIV) ? 4'b1101 : 4'b1110) || key_valid !== 1'b0) begin
        bad++;
        $display("FAIL post_rst k=%0d got col=%b v=%b", k, col_out, key_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    int hold, gap;
    for (int s = 0; s < 30; s++) begin
      k = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) k = k | (16'h0001 << $urandom_range(0, 15));
      hold = $urandom_range(1, 10) * CLK_DIV + $urandom_range(0, 3);
      gap  = $urandom_range(0, 8) * CLK_DIV + $urandom_range(0, 3);
      set_keys(k);
      for (int i = 0; i < hold + gap; i++) begin
        if (i == hold) set_keys('0);
        key_ack = ($urandom_range(0, 2) == 0);
        step();
        total++;
        if (col_out !== colpat(m_col) || key_valid !== m_valid || key_code !== m_code || key_lost !== m_lost) begin
          bad++;
          $display("FAIL random s=%0d got col=%b v=%b c=%h l=%b want col=%b v=%b c=%h l=%b",
                   s, col_out, key_valid, key_code, key_lost, colpat(m_col), m_valid, m_code, m_lost);
        end
      end
      key_ack = 1'b0;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_idle_scan();
    test_press_hold();
    test_bounce();
    test_lost();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
